// File: rtl/grf_mp.sv
// rtl/grf_mp.sv - multi-port register file with dual write ports, write-through bypass and pending scoreboard
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset clears registers, pending bits, pend_cnt
//   rd_addr / rd_data    NRD packed read ports, combinational with bypass from both write ports
//   rd_pend              per read port: registered pending bit of the addressed register
//   we0/wa0/wd0/pc0      write port 0 (WB stage)
//   we1/wa1/wd1/pc1      write port 1 (late writer, younger than port 0)
//   claim_en/claim_addr  mark a register pending at issue of a multi-cycle producer
//   pend_cnt             registered number of pending registers
module grf_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int TRACE    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_pend,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic [31:0]           pc0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic [31:0]           pc1,
  input  logic                  claim_en,
  input  logic [ADDR_W-1:0]     claim_addr,
  output logic [ADDR_W:0]       pend_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_next;
  logic [CW-1:0]     cnt_next;
  logic              eff0;
  logic              eff1;
  logic              win0;
  logic              claim_eff;

  // Gating with reset keeps the bypass paths quiet while the array is held clear.
  assign eff0      = reset && we0 && !(ZR && wa0 == '0);
  assign eff1      = reset && we1 && !(ZR && wa1 == '0);
  // Port 1 is younger: on a same-address collision port 0 is dropped entirely.
  assign win0      = eff0 && !(eff1 && wa1 == wa0);
  assign claim_eff = claim_en && !(ZR && claim_addr == '0);

  // Claim is applied last so a same-cycle write cannot erase a younger producer's claim.
  always_comb begin
    pend_next = pend;
    if (eff0) pend_next[wa0] = 1'b0;
    if (eff1) pend_next[wa1] = 1'b0;
    if (claim_eff) pend_next[claim_addr] = 1'b1;
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) cnt_next = cnt_next + CW'(pend_next[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (win0) regs[wa0] <= wd0;
      if (eff1) regs[wa1] <= wd1;
      pend     <= pend_next;
      pend_cnt <= cnt_next;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W] = (ZR && a == '0)      ? '0  :
                                         (eff1 && wa1 == a)   ? wd1 :
                                         (eff0 && wa0 == a)   ? wd0 :
                                                                regs[a];
    // Registered bit only; the hazard unit folds in the bypass itself.
    assign rd_pend[k] = pend[a];
  end

  logic unused_pc;
  assign unused_pc = ^{pc0, pc1};

  if (TRACE != 0) begin : g_trace
`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (reset) begin
        if (win0) $display("%0t@%h: $%0d <= %h", $time, pc0, wa0, wd0);
        if (eff1) $display("%0t@%h: $%0d <= %h", $time, pc1, wa1, wd1);
      end
    end
`endif
  end

endmodule

// File: tb/tb_grf_mp.sv
// tb/tb_grf_mp.sv - self-checking bench for grf_mp against a register-file reference model
module tb_grf_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int PW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data;
  logic [NR-1:0]      rd_pend;
  logic               we0, we1, claim_en;
  logic [AW-1:0]      wa0, wa1, claim_addr;
  logic [DW-1:0]      wd0, wd1;
  logic [31:0]        pc0, pc1;
  logic [AW:0]        pend_cnt;

  logic [4*AW-1:0]    p_rd_addr;
  logic [4*PW-1:0]    p_rd_data;
  logic [3:0]         p_rd_pend;
  logic               p_we0;
  logic [AW-1:0]      p_wa0;
  logic [PW-1:0]      p_wd0;
  logic [AW:0]        p_pend_cnt;

  grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1), .TRACE(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .we0(we0), .wa0(wa0), .wd0(wd0), .pc0(pc0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .pc1(pc1),
    .claim_en(claim_en), .claim_addr(claim_addr), .pend_cnt(pend_cnt)
  );

  grf_mp #(.DATA_W(PW), .ADDR_W(AW), .NRD(4), .ZERO_REG(0), .TRACE(0)) dut_p (
    .clk(clk), .reset(reset), .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_pend(p_rd_pend),
    .we0(p_we0), .wa0(p_wa0), .wd0(p_wd0), .pc0(32'h0),
    .we1(1'b0), .wa1('0), .wd1('0), .pc1(32'h0),
    .claim_en(1'b0), .claim_addr('0), .pend_cnt(p_pend_cnt)
  );

  int n_eval = 0;
  int n_fail = 0;

  logic [DW-1:0] m_reg  [32];
  logic          m_pend [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; claim_en = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; claim_addr = '0;
    pc0 = 32'h0; pc1 = 32'h0;
  endtask

  // A read must return what the register will hold once this cycle's writes
  // land in program order (port 0 older, port 1 younger); register 0 stays 0.
  task automatic step(input string tag);
    logic [DW-1:0] nxt [32];
    logic [AW-1:0] a;
    #2;
    for (int i = 0; i < 32; i++) nxt[i] = m_reg[i];
    if (reset) begin
      if (we0) nxt[wa0] = wd0;
      if (we1) nxt[wa1] = wd1;
    end
    nxt[0] = '0;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      chk({tag, "_rd_data"}, 64'(rd_data[k*DW +: DW]), 64'(nxt[a]));
      chk({tag, "_rd_pend"}, 64'(rd_pend[k]), 64'(m_pend[a]));
    end
    chk({tag, "_pend_cnt"}, 64'(pend_cnt), 64'(m_count()));
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_reg[i] = nxt[i];
      if (we0) m_pend[wa0] = 1'b0;
      if (we1) m_pend[wa1] = 1'b0;
      if (claim_en) m_pend[claim_addr] = 1'b1;
      m_pend[0] = 1'b0;
    end
    #1;
  endtask

  function automatic logic [NR*AW-1:0] rda(input int p1, input int p0);
    return {AW'(p1), AW'(p0)};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_pend[i] = 1'b0; end
    idle();
    p_we0 = 1'b0; p_wa0 = '0; p_wd0 = '0; p_rd_addr = '0;
    reset = 1'b0;
    // Held in reset: zero-register write and a bypass candidate both ignored.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEADBEEF; rd_addr = rda(5, 0);
    step("rst_zero");
    wa0 = 5'd5; wd0 = 32'h0BAD0BAD;
    step("rst_bypass");
    reset = 1'b1;
    idle(); we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEADBEEF; rd_addr = rda(0, 0);
    step("zero_write");
    idle(); rd_addr = rda(0, 0);
    step("zero_after");
    // Bypass from port 0.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h12345678; pc0 = 32'h100; rd_addr = rda(6, 5);
    step("bypass");
    idle();
    step("bypass_after");
    // Same-address collision: port 1 wins.
    we0 = 1'b1; we1 = 1'b1; wa0 = 5'd9; wa1 = 5'd9;
    wd0 = 32'hAAAA0000; wd1 = 32'h0000BBBB; pc0 = 32'h200; pc1 = 32'h204; rd_addr = rda(9, 9);
    step("collide");
    idle();
    step("collide_after");
    // Scoreboard.
    rd_addr = rda(7, 7);
    claim_en = 1'b1; claim_addr = 5'd7;
    step("claim7");
    idle();
    step("claim7_after");
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h77777777; pc1 = 32'h300;
    step("wb7");
    idle();
    step("wb7_after");
    claim_en = 1'b1; claim_addr = 5'd7; we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h70707070;
    step("claim_wb7");
    idle();
    step("claim_wb7_after");
    claim_en = 1'b1; claim_addr = 5'd0; rd_addr = rda(7, 0);
    step("claim0");
    idle();
    step("claim0_after");
    claim_en = 1'b1; claim_addr = 5'd7;
    step("reclaim7");
    idle(); we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h1;
    step("reclaim_wb7");
    idle();
    step("reclaim_after");
    // Random traffic, narrow address range to force collisions and re-claims.
    for (int n = 0; n < 300; n++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = AW'($urandom_range(0, 15)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = AW'($urandom_range(0, 15)); wd1 = $urandom;
      pc0 = $urandom; pc1 = $urandom;
      claim_en = ($urandom_range(0, 2) == 0); claim_addr = AW'($urandom_range(0, 15));
      rd_addr = rda($urandom_range(0, 15), $urandom_range(0, 15));
      step("rand");
    end
    // Async reset between edges with state present.
    idle(); we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h22;
    claim_en = 1'b1; claim_addr = 5'd4;
    step("pre_a");
    idle(); we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33; claim_en = 1'b1; claim_addr = 5'd8; rd_addr = rda(2, 1);
    step("pre_b");
    idle(); rd_addr = rda(4, 3);
    step("pre_c");
    rd_addr = rda(2, 4); we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h99;
    #3;
    reset = 1'b0;
    #1;
    chk("async_rd0", 64'(rd_data[DW-1:0]), 64'h0);
    chk("async_rd1", 64'(rd_data[2*DW-1:DW]), 64'h0);
    chk("async_pend", 64'(rd_pend), 64'h0);
    chk("async_cnt", 64'(pend_cnt), 64'h0);
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_pend[i] = 1'b0; end
    @(posedge clk); #1;
    reset = 1'b1; idle(); rd_addr = rda(3, 1);
    step("post_reset");
    // Wide variant without a hardwired zero register.
    p_we0 = 1'b1; p_wa0 = 5'd0; p_wd0 = 64'hFFFF_FFFF_FFFF_FFFF; p_rd_addr = '0;
    #2;
    chk("p_bypass0", p_rd_data[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    p_we0 = 1'b0; p_wd0 = '0;
    #1;
    for (int k = 0; k < 4; k++) chk("p_read0", p_rd_data[k*PW +: PW], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("p_cnt", 64'(p_pend_cnt), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
